game_round_sequencer: RTL and testbench
=======================================

GAME_ROUND_SEQUENCER -- requirements
Module: game_round_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_FRAMES, default 3, meaning consecutive agreeing frame samples needed to change the debounced key level (range 1..15).
REQ-002 The block SHALL have parameter RELOAD_FRAMES, default 30, meaning frame ticks spent in RELOAD after each shot (range 1..63).
REQ-003 The block SHALL have parameter SHOTS_PER_ROUND, default 8, meaning torpedoes available per round (range 1..15).
REQ-004 The block SHALL have parameter HITS_TO_WIN, default 5, meaning hits that end a round as won (range 1..SHOTS_PER_ROUND).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 key  input  1  raw fire button, active-high, asynchronous to nothing (already in clk domain), bouncy.
REQ-008 frame_tick  input  1  one-cycle pulse once per video frame.
REQ-009 target_within_screen  input  1  target sprite currently on screen.
REQ-010 torpedo_within_screen  input  1  torpedo sprite currently on screen.
REQ-011 collision  input  1  target/torpedo overlap flag.
REQ-012 target_write  output  1  one-cycle pulse loading a new target sprite.
REQ-013 torpedo_write  output  1  one-cycle pulse launching a torpedo.
REQ-014 shots_left  output  4  torpedoes remaining in current round.
REQ-015 hits  output  4  hits scored in current round.
REQ-016 round_over  output  1  high while in OVER.
REQ-017 round_won  output  1  valid while round_over; 1 = won, 0 = lost.

Function
REQ-018 Debounce: key SHALL be sampled only on frame_tick cycles; debounced level SHALL flip after DEBOUNCE_FRAMES consecutive samples differing from it; any agreeing sample SHALL clear the disagreement counter.
REQ-019 press SHALL be a one-cycle internal pulse on each 0->1 transition of the debounced level; presses not consumed in the current state SHALL be dropped, never queued.
REQ-020 States SHALL be IDLE, SPAWN, ARMED, FLY, RELOAD, OVER.
REQ-021 IDLE / OVER: on press -> SPAWN, same cycle load shots_left=SHOTS_PER_ROUND, hits=0, clear round_won.
REQ-022 SPAWN: target_write=1 for exactly one cycle, then unconditionally -> ARMED.
REQ-023 ARMED: on press (shots_left>0 always holds here) -> FLY with torpedo_write=1 for that one cycle and shots_left decremented; else if target_within_screen=0 -> SPAWN; press wins if both occur.
REQ-024 FLY: collision=1 -> hits+1, -> RELOAD; else torpedo_within_screen=0 -> RELOAD (miss); collision and exit in same cycle SHALL count as hit; target exit in FLY SHALL be ignored; the first FLY cycle SHALL ignore torpedo_within_screen (sprite load latency).
REQ-025 RELOAD: count frame_ticks from 0; on the RELOAD_FRAMES-th tick: hits==HITS_TO_WIN -> OVER, round_won=1; else shots_left==0 -> OVER, round_won=0; else -> SPAWN.
REQ-026 hits SHALL saturate at 15; shots_left SHALL never underflow.
REQ-027 target_write and torpedo_write SHALL never be high in the same cycle; each pulse SHALL be registered (output of a flop).
REQ-028 Outputs SHALL be Moore-registered: shots_left/hits/round_won change on the same edge as the state transition causing them.

Reset
REQ-029 While reset=1 at a clk edge: state=IDLE, debounced level=0, debounce and reload counters=0, target_write=0, torpedo_write=0, shots_left=0, hits=0, round_over=0, round_won=0.
REQ-030 Reset asserted in any state, including mid-FLY or mid-RELOAD, SHALL take effect on the next edge with no pending pulse emitted afterwards.
REQ-031 A key held high through reset release SHALL produce a press only after DEBOUNCE_FRAMES frame_ticks.

Verification
REQ-032 Reset, key=1 held, 3 frame_ticks -> single press; IDLE->SPAWN; shots_left=8, hits=0; one target_write pulse next cycle.
REQ-033 key toggling every frame for 20 frames (DEBOUNCE_FRAMES=3) -> no press, state stays IDLE.
REQ-034 ARMED, press; collision=1 on 5th FLY cycle -> torpedo_write one pulse, shots_left=7, hits=1, RELOAD; SPAWN after exactly 30 frame_ticks.
REQ-035 ARMED, press with target_within_screen=0 same cycle -> FLY, torpedo_write=1, no target_write.
REQ-036 Eight shots, five hits -> OVER, round_over=1, round_won=1 after 5th reload; eight misses -> OVER, round_won=0, shots_left=0; next press -> SPAWN, shots_left=8, hits=0.
REQ-037 reset=1 during RELOAD with hits=3 -> next edge all outputs 0, IDLE; no target_write follows.

Source files
------------

// File: rtl/game_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_round_sequencer
// Brief    : Debounced fire key and torpedo-round state machine (spawn/shoot/reload).
// Revision : 1.0
// ============================================================================
module game_round_sequencer #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int RELOAD_FRAMES   = 30,
    parameter int SHOTS_PER_ROUND = 8,
    parameter int HITS_TO_WIN     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    input  logic       frame_tick,
    input  logic       target_within_screen,
    input  logic       torpedo_within_screen,
    input  logic       collision,
    output logic       target_write,
    output logic       torpedo_write,
    output logic [3:0] shots_left,
    output logic [3:0] hits,
    output logic       round_over,
    output logic       round_won
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_spawn  = 3'd1;
    localparam logic [2:0] c_armed  = 3'd2;
    localparam logic [2:0] c_fly    = 3'd3;
    localparam logic [2:0] c_reload = 3'd4;
    localparam logic [2:0] c_over   = 3'd5;

    localparam logic [3:0] c_db_last     = 4'(DEBOUNCE_FRAMES - 1);
    localparam logic [5:0] c_reload_last = 6'(RELOAD_FRAMES - 1);
    localparam logic [3:0] c_shots       = 4'(SHOTS_PER_ROUND);
    localparam logic [3:0] c_win_hits    = 4'(HITS_TO_WIN);
    localparam logic [3:0] c_hits_max    = 4'd15;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    logic [3:0] r_db_cnt;
    logic       r_key_level;
    logic       r_key_level_d;
    logic       w_press;

    logic [5:0] r_reload_cnt;
    logic       w_reload_done;

    logic       r_target_write;
    logic       r_torpedo_write;
    logic [3:0] r_shots_left;
    logic [3:0] r_hits;
    logic       r_round_over;
    logic       r_round_won;

    logic       w_target_write_nxt;
    logic       w_torpedo_write_nxt;
    logic [3:0] w_shots_left_nxt;
    logic [3:0] w_hits_nxt;
    logic       w_round_over_nxt;
    logic       w_round_won_nxt;
    logic       w_fly_first;

    // Debouncer: key is only looked at on frame ticks; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_level   <= 1'b0;
            r_key_level_d <= 1'b0;
            r_db_cnt      <= 4'd0;
        end else begin
            r_key_level_d <= r_key_level;
            if (frame_tick) begin
                if (key == r_key_level) begin
                    r_db_cnt <= 4'd0;
                end else if (r_db_cnt >= c_db_last) begin
                    r_key_level <= key;
                    r_db_cnt    <= 4'd0;
                end else begin
                    r_db_cnt <= r_db_cnt + 4'd1;
                end
            end
        end
    end

    assign w_press = r_key_level & ~r_key_level_d;

    always_ff @(posedge clk) begin
        if (reset || (r_state != c_reload)) begin
            r_reload_cnt <= 6'd0;
        end else if (frame_tick) begin
            r_reload_cnt <= w_reload_done ? 6'd0 : r_reload_cnt + 6'd1;
        end
    end

    assign w_reload_done = (r_state == c_reload) && frame_tick && (r_reload_cnt == c_reload_last);

    // torpedo_write is high exactly during the first FLY cycle, while the sprite is still loading.
    assign w_fly_first = r_torpedo_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle, c_over: begin
                if (w_press) w_next_state = c_spawn;
            end
            c_spawn: begin
                w_next_state = c_armed;
            end
            c_armed: begin
                if (w_press)                    w_next_state = c_fly;
                else if (!target_within_screen) w_next_state = c_spawn;
            end
            c_fly: begin
                if (collision)                                     w_next_state = c_reload;
                else if (!w_fly_first && !torpedo_within_screen)   w_next_state = c_reload;
            end
            c_reload: begin
                if (w_reload_done) begin
                    if (r_hits == c_win_hits)      w_next_state = c_over;
                    else if (r_shots_left == 4'd0) w_next_state = c_over;
                    else                           w_next_state = c_spawn;
                end
            end
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        w_shots_left_nxt    = r_shots_left;
        w_hits_nxt          = r_hits;
        w_round_won_nxt     = r_round_won;
        w_target_write_nxt  = (w_next_state == c_spawn);
        w_torpedo_write_nxt = (r_state == c_armed) && w_press;
        w_round_over_nxt    = (w_next_state == c_over);
        case (r_state)
            c_idle, c_over: begin
                if (w_press) begin
                    w_shots_left_nxt = c_shots;
                    w_hits_nxt       = 4'd0;
                    w_round_won_nxt  = 1'b0;
                end
            end
            c_armed: begin
                if (w_press && (r_shots_left != 4'd0)) w_shots_left_nxt = r_shots_left - 4'd1;
            end
            c_fly: begin
                if (collision && (r_hits != c_hits_max)) w_hits_nxt = r_hits + 4'd1;
            end
            c_reload: begin
                if (w_reload_done && (r_hits == c_win_hits)) w_round_won_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_target_write  <= 1'b0;
            r_torpedo_write <= 1'b0;
            r_shots_left    <= 4'd0;
            r_hits          <= 4'd0;
            r_round_over    <= 1'b0;
            r_round_won     <= 1'b0;
        end else begin
            r_target_write  <= w_target_write_nxt;
            r_torpedo_write <= w_torpedo_write_nxt;
            r_shots_left    <= w_shots_left_nxt;
            r_hits          <= w_hits_nxt;
            r_round_over    <= w_round_over_nxt;
            r_round_won     <= w_round_won_nxt;
        end
    end

    assign target_write  = r_target_write;
    assign torpedo_write = r_torpedo_write;
    assign shots_left    = r_shots_left;
    assign hits          = r_hits;
    assign round_over    = r_round_over;
    assign round_won     = r_round_won;

endmodule
`default_nettype wire

// File: tb/tb_game_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_round_sequencer
// Brief    : Directed self-checking bench for game_round_sequencer (default parameters).
// Revision : 1.0
// ============================================================================
module tb_game_round_sequencer;

    localparam int c_RELOAD = 30;

    logic       clk;
    logic       reset;
    logic       key;
    logic       frame_tick;
    logic       target_within_screen;
    logic       torpedo_within_screen;
    logic       collision;
    logic       target_write;
    logic       torpedo_write;
    logic [3:0] shots_left;
    logic [3:0] hits;
    logic       round_over;
    logic       round_won;

    int n_checks = 0;
    int n_errors = 0;
    int tw_cnt   = 0;
    int pw_cnt   = 0;
    int both_cnt = 0;
    int tw_base  = 0;
    int pw_base  = 0;

    game_round_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .key                   (key),
        .frame_tick            (frame_tick),
        .target_within_screen  (target_within_screen),
        .torpedo_within_screen (torpedo_within_screen),
        .collision             (collision),
        .target_write          (target_write),
        .torpedo_write         (torpedo_write),
        .shots_left            (shots_left),
        .hits                  (hits),
        .round_over            (round_over),
        .round_won             (round_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (target_write)                  tw_cnt++;
        if (torpedo_write)                 pw_cnt++;
        if (target_write && torpedo_write) both_cnt++;
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    // Holds key for three frames; the press is consumed on the final step.
    task automatic press(input logic tws_at_press);
        key = 1'b1;
        frame();
        frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        target_within_screen = tws_at_press;
        step();
        target_within_screen = 1'b1;
    endtask

    task automatic shoot(input bit hit);
        press(1'b1);
        if (hit) collision = 1'b1;
        else     torpedo_within_screen = 1'b0;
        step();
        collision = 1'b0;
        if (!hit) step();
        torpedo_within_screen = 1'b1;
        key = 1'b0;
        repeat (c_RELOAD) frame();
    endtask

    initial begin
        reset = 1'b1;
        key = 1'b1;
        frame_tick = 1'b0;
        target_within_screen = 1'b1;
        torpedo_within_screen = 1'b1;
        collision = 1'b0;
        repeat (2) step();
        frame();
        check("rst_target_write", int'(target_write), 0);
        check("rst_torpedo_write", int'(torpedo_write), 0);
        check("rst_shots_left", int'(shots_left), 0);
        check("rst_hits", int'(hits), 0);
        check("rst_round_over", int'(round_over), 0);
        check("rst_round_won", int'(round_won), 0);

        // Key held through reset release: press only on the third post-reset tick.
        reset = 1'b0;
        frame();
        frame();
        check("no_early_press", int'(shots_left), 0);
        frame();
        check("start_shots", int'(shots_left), 8);
        check("start_hits", int'(hits), 0);
        check("spawn_pulse", int'(target_write), 1);
        step();
        check("spawn_one_cycle", int'(target_write), 0);
        check("spawn_count", tw_cnt, 1);
        key = 1'b0;
        repeat (3) frame();

        target_within_screen = 1'b0;
        step();
        check("respawn_pulse", int'(target_write), 1);
        target_within_screen = 1'b1;
        step();
        check("respawn_count", tw_cnt, 2);

        // Shot 1: collision on the fifth FLY cycle, then a 30-frame reload.
        press(1'b1);
        check("fire_pulse", int'(torpedo_write), 1);
        check("fire_no_target", int'(target_write), 0);
        check("fire_shots", int'(shots_left), 7);
        step();
        check("fire_one_cycle", int'(torpedo_write), 0);
        repeat (3) step();
        collision = 1'b1;
        step();
        collision = 1'b0;
        check("hit1", int'(hits), 1);
        key = 1'b0;
        repeat (c_RELOAD - 1) frame();
        check("no_early_spawn", tw_cnt, 2);
        frame();
        check("spawn_after_reload", tw_cnt, 3);

        // Shot 2: target leaves on the press cycle; first FLY cycle ignores torpedo exit.
        press(1'b0);
        check("press_wins_fire", int'(torpedo_write), 1);
        check("press_wins_no_spawn", int'(target_write), 0);
        check("shots_after_2", int'(shots_left), 6);
        torpedo_within_screen = 1'b0;
        step();
        collision = 1'b1;
        step();
        collision = 1'b0;
        torpedo_within_screen = 1'b1;
        check("first_fly_ignore", int'(hits), 2);
        key = 1'b0;
        repeat (c_RELOAD) frame();
        check("spawn_count_2", tw_cnt, 4);

        // Shot 3: target exit in FLY ignored; collision with exit counts as hit.
        press(1'b1);
        target_within_screen = 1'b0;
        repeat (2) step();
        check("fly_ignores_target", tw_cnt, 4);
        torpedo_within_screen = 1'b0;
        collision = 1'b1;
        step();
        collision = 1'b0;
        torpedo_within_screen = 1'b1;
        target_within_screen = 1'b1;
        check("hit_and_exit", int'(hits), 3);
        key = 1'b0;
        repeat (c_RELOAD) frame();

        shoot(1'b1);
        check("no_over_yet", int'(round_over), 0);
        shoot(1'b1);
        check("win_over", int'(round_over), 1);
        check("win_won", int'(round_won), 1);
        check("win_hits", int'(hits), 5);
        check("win_shots", int'(shots_left), 3);
        check("win_no_spawn", tw_cnt, 6);

        press(1'b1);
        check("restart_shots", int'(shots_left), 8);
        check("restart_hits", int'(hits), 0);
        check("restart_over", int'(round_over), 0);
        check("restart_won", int'(round_won), 0);
        check("restart_spawn", int'(target_write), 1);
        step();
        key = 1'b0;
        repeat (3) frame();

        repeat (8) shoot(1'b0);
        check("lose_over", int'(round_over), 1);
        check("lose_won", int'(round_won), 0);
        check("lose_shots", int'(shots_left), 0);
        check("lose_hits", int'(hits), 0);

        press(1'b1);
        check("replay_shots", int'(shots_left), 8);
        check("replay_hits", int'(hits), 0);
        check("replay_over", int'(round_over), 0);
        step();
        key = 1'b0;
        repeat (3) frame();

        // Reset mid-RELOAD with three hits scored.
        shoot(1'b1);
        shoot(1'b1);
        press(1'b1);
        collision = 1'b1;
        step();
        collision = 1'b0;
        key = 1'b0;
        repeat (5) frame();
        check("pre_reset_hits", int'(hits), 3);
        reset = 1'b1;
        step();
        check("mid_rst_shots", int'(shots_left), 0);
        check("mid_rst_hits", int'(hits), 0);
        check("mid_rst_over", int'(round_over), 0);
        check("mid_rst_won", int'(round_won), 0);
        check("mid_rst_tw", int'(target_write), 0);
        check("mid_rst_pw", int'(torpedo_write), 0);
        reset = 1'b0;
        tw_base = tw_cnt;
        pw_base = pw_cnt;
        repeat (40) frame();
        check("no_pulse_after_rst_tw", tw_cnt, tw_base);
        check("no_pulse_after_rst_pw", pw_cnt, pw_base);

        // Bouncing key in IDLE never yields a press.
        for (int i = 0; i < 20; i++) begin
            key = ~key;
            frame();
        end
        step();
        check("bounce_shots", int'(shots_left), 0);
        check("bounce_no_spawn", tw_cnt, tw_base);
        check("pulse_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
